// File: rtl/stq_pkg.sv
// rtl/stq_pkg.sv - shared constants and FSM state type for the store-queue drain controller
package stq_pkg;

  localparam int STQ_BUF_COUNT = 32;
  localparam int STQ_PTR_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } stq_drain_state_t;

endpackage

// File: rtl/stq_ptr_mask.sv
// rtl/stq_ptr_mask.sv - one- or two-hot entry mask starting at a wrapping pointer
module stq_ptr_mask #(
  parameter int BUF_COUNT = 32,
  parameter int PTR_W     = 5
) (
  input  logic [PTR_W-1:0]     ptr,
  input  logic [1:0]           cnt,
  output logic [BUF_COUNT-1:0] mask
);

  logic [PTR_W-1:0] ptr_next;

  // The second entry wraps naturally through the PTR_W-bit adder.
  assign ptr_next = ptr + PTR_W'(1);

  // Mark ptr for a count of 1 or 2, and ptr+1 as well for a count of 2.
  always_comb begin
    mask = '0;
    if (cnt == 2'd1 || cnt == 2'd2) mask[ptr] = 1'b1;
    if (cnt == 2'd2) mask[ptr_next] = 1'b1;
  end

endmodule

// File: rtl/stq_drain_l.sv
// rtl/stq_drain_l.sv - store-queue retire/drain controller; optional pair drain under STQ_DRAIN_PAIR_EN
module stq_drain_l
  import stq_pkg::*;
#(
  parameter int BUF_COUNT = STQ_BUF_COUNT,
  parameter int PTR_W     = STQ_PTR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallA,
  input  logic                 ret_en,
  input  logic [1:0]           ret_cnt,
  input  logic [BUF_COUNT-1:0] free,
  output logic [BUF_COUNT-1:0] passe_en,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [PTR_W-1:0]     wr_idx,
  output logic                 wr_pair,
  input  logic                 wr_ack,
  input  logic                 wr_retry,
  output logic [BUF_COUNT-1:0] free_en,
  output logic [PTR_W:0]       pending,
  output logic                 err
);

  stq_drain_state_t state, state_next;

  logic [PTR_W-1:0]     ret_ptr;
  logic [PTR_W-1:0]     head_ptr;
  logic                 pair_q;
  logic                 pair_ok;
  logic                 ret_valid;
  logic                 ret_acc;
  logic                 ret_ovf;
  logic [1:0]           acc_cnt;
  logic                 drain;
  logic [1:0]           drain_n;
  logic [PTR_W:0]       post_drain;
  logic [PTR_W+1:0]     room_sum;
  logic [PTR_W:0]       pending_next;
  logic [BUF_COUNT-1:0] ret_mask;
  logic [BUF_COUNT-1:0] free_mask;

  // A drain completes only on a non-retry ack while a request is outstanding.
  assign drain   = (state == WAIT) && wr_ack && !wr_retry;
  assign drain_n = drain ? (pair_q ? 2'd2 : 2'd1) : 2'd0;

  // The drain of this cycle frees room for a retire in the same cycle.
  assign post_drain   = pending - {{(PTR_W-1){1'b0}}, drain_n};
  assign room_sum     = {1'b0, post_drain} + {{PTR_W{1'b0}}, ret_cnt};
  assign ret_valid    = ret_en && (ret_cnt == 2'd1 || ret_cnt == 2'd2);
  assign ret_acc      = ret_valid && (room_sum <= (PTR_W+2)'(BUF_COUNT));
  assign ret_ovf      = ret_valid && !ret_acc;
  assign acc_cnt      = ret_acc ? ret_cnt : 2'd0;
  assign pending_next = post_drain + {{(PTR_W-1){1'b0}}, acc_cnt};

`ifdef STQ_DRAIN_PAIR_EN
  assign pair_ok = (pending_next >= (PTR_W+1)'(2)) && !head_ptr[0];
`else
  assign pair_ok = 1'b0;
`endif

  stq_ptr_mask #(.BUF_COUNT(BUF_COUNT), .PTR_W(PTR_W)) u_ret_mask (
    .ptr  (ret_ptr),
    .cnt  (acc_cnt),
    .mask (ret_mask)
  );

  stq_ptr_mask #(.BUF_COUNT(BUF_COUNT), .PTR_W(PTR_W)) u_free_mask (
    .ptr  (head_ptr),
    .cnt  (drain_n),
    .mask (free_mask)
  );

  assign passe_en = rst ? ret_mask : '0;
  assign wr_valid = (state == REQ);
  assign wr_idx   = head_ptr;
  assign wr_pair  = pair_q;

  // Next-state: launch on committed work when not stalled, retry re-enters REQ.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pending_next != '0 && !stallA) state_next = REQ;
      REQ:     if (wr_ready) state_next = WAIT;
      WAIT:    if (wr_ack) state_next = wr_retry ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, pointers, occupancy, release strobe and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ret_ptr  <= '0;
      head_ptr <= '0;
      pending  <= '0;
      pair_q   <= 1'b0;
      free_en  <= '0;
      err      <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      free_en <= free_mask;
      if (ret_acc) ret_ptr <= ret_ptr + {{(PTR_W-2){1'b0}}, ret_cnt};
      if (drain) head_ptr <= head_ptr + {{(PTR_W-2){1'b0}}, drain_n};
      if (state == IDLE && state_next == REQ) pair_q <= pair_ok;
      else if (drain) pair_q <= 1'b0;
      if (ret_ovf || (wr_ack && state != WAIT) || (state == REQ && free[head_ptr]))
        err <= 1'b1;
    end
  end

endmodule

// File: doc/stq_drain_l.md
# stq_drain_L

Store-queue drain controller for the 32-entry store-queue buffer array. It converts in-order retirement of stores into per-entry `passe_en` strobes. It then drains committed entries oldest-first to the L1 write port through a valid/ready request plus ack/retry response handshake. On each successful ack it pulses `free_en` for the drained entry, so it is the reader/releaser counterpart of the array's write/check side.

## Interface
Parameters:
- BUF_COUNT, 32, number of store-queue entries (power of two)
- PTR_W, 5, log2(BUF_COUNT)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- stallA  in  1  blocks launch of a new request; no effect on in-flight request
- ret_en  in  1  retirement of stores this cycle
- ret_cnt  in  2  stores retired (1 or 2; 0/3 ignored)
- free  in  BUF_COUNT  per-entry free flags from the buffer array
- passe_en  out  BUF_COUNT  combinational mask: entries at ret_ptr (and ret_ptr+1 if ret_cnt==2), gated by accepted ret_en
- wr_valid  out  1  write request valid
- wr_ready  in  1  L1 accepts request
- wr_idx  out  PTR_W  entry index of request (head_ptr)
- wr_pair  out  1  request covers head_ptr and head_ptr+1 (STQ_DRAIN_PAIR_EN only, else 0)
- wr_ack  in  1  L1 response
- wr_retry  in  1  qualifies wr_ack: request must be reissued
- free_en  out  BUF_COUNT  registered one-cycle strobe releasing drained entries
- pending  out  PTR_W+1  committed, not yet freed entry count
- err  out  1  sticky error flag

## Operation
- Pointers ret_ptr and head_ptr (PTR_W bits) wrap modulo BUF_COUNT; pending in 0..BUF_COUNT.
- Retire acceptance: ret_en && ret_cnt in {1,2} && pending+ret_cnt <= BUF_COUNT. Accepted: ret_ptr += ret_cnt, passe_en mask driven. Rejected with ret_en high and overflow: passe_en=0, err set.
- FSM states IDLE, REQ, WAIT.
  - IDLE -> REQ when pending>0 and !stallA.
  - REQ: wr_valid=1, wr_idx=head_ptr, held stable until wr_ready. On wr_ready -> WAIT.
  - WAIT: wr_ack&&!wr_retry -> IDLE; drained n=1 (2 if pair); head_ptr += n; free_en for those entries next cycle. wr_ack&&wr_retry -> REQ, same index, no free_en.
- pending_next = pending + accepted ret_cnt − drained n. Simultaneous retire and drain both take effect.
- Check: free[head_ptr]==1 while in REQ sets err (request still issued).
- wr_ack outside WAIT is ignored and sets err.

## Timing
- Reset values: ret_ptr=head_ptr=0, pending=0, state IDLE, wr_valid=0, wr_pair=0, free_en=0, err=0. passe_en=0 while rst low.
- Reset mid-request drops the request immediately (async). No free_en is issued.
- Retire to passe_en: same cycle (combinational).
- Earliest first request: wr_valid is high 1 cycle after the retire that made pending>0.
- Ready to WAIT: 1 cycle. Ack to free_en: 1 cycle. Ack to next wr_valid: 2 cycles (IDLE then REQ).
- Full queue (pending==BUF_COUNT): a retire is accepted in the same cycle as a drain only if the post-drain count fits. Drain decrement visible that cycle = ack cycle.

## Configuration
- STQ_DRAIN_PAIR_EN defined: in IDLE->REQ, if pending>=2 and head_ptr is even, wr_pair=1 and one request drains two entries. free_en is two-hot, head_ptr += 2, including wrap 31->0 excluded (31 is odd).
- Undefined: wr_pair tied 0; one entry per request.

## Structure
- Package stq_pkg: STQ_BUF_COUNT, STQ_PTR_W constants; typedef enum stq_drain_state_t {IDLE, REQ, WAIT}.
- One sub-module stq_ptr_mask: (ptr, cnt) -> BUF_COUNT-bit mask with wrap. Used for both passe_en and free_en.

## Test plan
- Reset then ret_en=1, ret_cnt=2 -> passe_en=0x00000003 same cycle; pending=2; wr_valid next cycle with wr_idx=0.
- wr_ready=1, then wr_ack=1, wr_retry=0 -> free_en=0x00000001 one cycle after ack; pending=1; wr_idx=1 two cycles later.
- wr_ack with wr_retry=1 -> no free_en; wr_valid reasserts next cycle with same wr_idx; pending unchanged.
- ret_ptr=31, ret_cnt=2 -> passe_en=0x80000001; fill to pending=32, then ret_en with ret_cnt=1 -> passe_en=0, err=1.
- stallA=1 with pending=3 -> wr_valid stays 0. Deassert -> wr_valid next cycle. Assert stallA while in WAIT -> ack still completes.
- STQ_DRAIN_PAIR_EN, pending=4, head_ptr=0 -> wr_pair=1, free_en=0x00000003 after ack, then wr_idx=2.
